// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle sequencer for the 8-bit CPU.
// Fetches an instruction byte, pulses the decoder, latches the normalised
// one-hot op and drives the datapath strobes until the instruction retires.
module cpu_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ops,
  input  logic        zf,
  input  logic        cf,
  input  logic        mem_ready,
  input  logic        in_valid,
  input  logic        out_ready,
  output logic        decode_en,
  output logic        ir_ld,
  output logic        pc_inc,
  output logic        pc_ld,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        reg_we,
  output logic [1:0]  reg_src,
  output logic [2:0]  alu_op,
  output logic        flag_we,
  output logic        in_ack,
  output logic        out_valid,
  output logic        halted,
  output logic [2:0]  state
);

  localparam int unsigned OP_W = 16;

  // Op-class masks over the one-hot op vector.
  localparam logic [OP_W-1:0] M_EXEC = 16'h41F9;  // mova, ALU ops, nop
  localparam logic [OP_W-1:0] M_MEM  = 16'h0006;  // movb, movc
  localparam logic [OP_W-1:0] M_OPND = 16'h0E00;  // jmp, jz, jc
  localparam logic [OP_W-1:0] M_IO   = 16'h3000;  // in1, out1

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_OPND   = 3'd5,
    S_IO     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [OP_W-1:0] r_op;
  logic [OP_W-1:0] w_ops_norm;
  logic [OP_W-1:0] w_ops_lsb;
  logic            w_taken;
  logic            w_unused;

  // Keep only the lowest set op bit; an empty decode is a nop.
  assign w_ops_lsb  = ops & OP_W'(~ops + 16'd1);
  assign w_ops_norm = (ops == '0) ? 16'h4000 : w_ops_lsb;

  // Jump resolution uses the flags present in the operand-completing cycle.
  assign w_taken = r_op[9] | (r_op[10] & zf) | (r_op[11] & cf);

  // nop and halt need no per-op strobes once their state is reached.
  assign w_unused = ^r_op[15:14];

  assign state = r_state;

  // State and latched op register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RST;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= w_ops_norm;
    end
  end

  // Next state and all datapath strobes.
  always_comb begin
    w_next    = r_state;
    decode_en = 1'b0;
    ir_ld     = 1'b0;
    pc_inc    = 1'b0;
    pc_ld     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    reg_we    = 1'b0;
    reg_src   = 2'd0;
    alu_op    = 3'd0;
    flag_we   = 1'b0;
    in_ack    = 1'b0;
    out_valid = 1'b0;
    halted    = 1'b0;
    case (r_state)
      S_RST: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_ld  = 1'b1;
          pc_inc = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        decode_en = 1'b1;
        if      ((w_ops_norm & M_EXEC) != '0) w_next = S_EXEC;
        else if ((w_ops_norm & M_MEM)  != '0) w_next = S_MEM;
        else if ((w_ops_norm & M_OPND) != '0) w_next = S_OPND;
        else if ((w_ops_norm & M_IO)   != '0) w_next = S_IO;
        else                                  w_next = S_HALT;
      end
      S_EXEC: begin
        w_next = S_FETCH;
        if (r_op[0]) reg_we = 1'b1;
        if (r_op[8:3] != '0) begin
          reg_we  = 1'b1;
          flag_we = 1'b1;
        end
        if      (r_op[3]) alu_op = 3'd1;
        else if (r_op[4]) alu_op = 3'd2;
        else if (r_op[5]) alu_op = 3'd3;
        else if (r_op[6]) alu_op = 3'd4;
        else if (r_op[7]) alu_op = 3'd5;
        else if (r_op[8]) alu_op = 3'd6;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = r_op[1];
        if (mem_ready) begin
          w_next = S_FETCH;
          if (r_op[2]) begin
            reg_we  = 1'b1;
            reg_src = 2'd1;
          end
        end
      end
      S_OPND: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
          if (w_taken) pc_ld  = 1'b1;
          else         pc_inc = 1'b1;
        end
      end
      S_IO: begin
        if (r_op[12]) begin
          if (in_valid) begin
            in_ack  = 1'b1;
            reg_we  = 1'b1;
            reg_src = 2'd2;
            w_next  = S_FETCH;
          end
        end else begin
          out_valid = 1'b1;
          if (out_ready) w_next = S_FETCH;
        end
      end
      S_HALT: halted = 1'b1;
      default: w_next = S_RST;
    endcase
  end

endmodule
